// File: rtl/kyber_ntt_ctrl.sv
// kyber_ntt_ctrl: in-place 256-point Kyber NTT sequencer for a dual-port 256x12 RAM and an external butterfly unit.
// Defining KYBER_INTT_EN adds the mode input and bf_inv output for the inverse transform.
module kyber_ntt_ctrl #(
  parameter int BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef KYBER_INTT_EN
  input  logic       mode,
  output logic       bf_inv,
`endif
  output logic       busy,
  output logic       done,
  output logic       ram_we,
  output logic [7:0] ram_addr_a,
  output logic [7:0] ram_addr_b,
  output logic       bf_valid,
  output logic [6:0] bf_zeta_idx,
  output logic [2:0] ntt_layer
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;
  state_t state, nxt;
  logic [6:0] cnt, mask, g;
  logic [2:0] layer, sh;
  logic [3:0] wcnt;
  logic [7:0] len, j;
  logic inv, last;
  assign last = layer == 3'd6 && cnt == 7'd127;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      layer <= '0;
      wcnt  <= '0;
      done  <= 1'b0;
`ifdef KYBER_INTT_EN
      inv   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      done  <= state == WRITE && last;
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          layer <= '0;
`ifdef KYBER_INTT_EN
          inv   <= mode;
`endif
        end
        READ:  wcnt <= '0;
        WAIT:  wcnt <= wcnt + 4'd1;
        WRITE: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) layer <= last ? 3'd0 : layer + 3'd1;
        end
        default: ;
      endcase
    end
  end
`ifdef KYBER_INTT_EN
  assign bf_inv = inv;
`else
  assign inv = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? READ : IDLE;
      READ:    nxt = WAIT;
      WAIT:    nxt = (wcnt == 4'(BF_LAT - 1)) ? WRITE : WAIT;
      WRITE:   nxt = last ? IDLE : READ;
      default: nxt = IDLE;
    endcase
  end
  // log2(len): forward halves len each layer, inverse doubles it
  always_comb begin
    sh   = inv ? layer + 3'd1 : 3'd7 - layer;
    len  = 8'd1 << sh;
    mask = 7'(len - 8'd1);
    g    = cnt >> sh;
    j    = {cnt & ~mask, 1'b0} + {1'b0, cnt & mask};
  end
  assign busy        = state != IDLE;
  assign ram_we      = state == WRITE;
  assign bf_valid    = state == WAIT && wcnt == 4'd0;
  assign ntt_layer   = layer;
  assign ram_addr_a  = busy ? j : 8'd0;
  assign ram_addr_b  = busy ? j + len : 8'd0;
  assign bf_zeta_idx = !busy ? 7'd0 :
                       inv ? 7'((8'd128 >> layer) - 8'd1) - g : (7'd1 << layer) + g;
endmodule

// File: tb/tb_kyber_ntt_ctrl.sv
// tb_kyber_ntt_ctrl: scoreboard bench with a behavioural RAM and butterfly unit around kyber_ntt_ctrl.
module tb_kyber_ntt_ctrl;
  localparam int BF_LAT = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, ram_we, bf_valid;
  logic [7:0] ram_addr_a, ram_addr_b;
  logic [6:0] bf_zeta_idx;
  logic [2:0] ntt_layer;
`ifdef KYBER_INTT_EN
  logic mode = 1'b0, bf_inv;
`endif

  kyber_ntt_ctrl #(.BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef KYBER_INTT_EN
    .mode(mode), .bf_inv(bf_inv),
`endif
    .busy(busy), .done(done), .ram_we(ram_we),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .bf_valid(bf_valid), .bf_zeta_idx(bf_zeta_idx), .ntt_layer(ntt_layer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] z;
    logic [2:0] l;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0, writes = 0, dones = 0, cyc = 0, vcyc = 0;
  logic [11:0] mem [256];
  logic [11:0] gold [256];
  logic [11:0] dout_a, dout_b, ca, cb, din_a, din_b;
  logic [6:0] cz;
  logic [7:0] va, vb;

  assign din_a = ca + 12'(cb * 12'(cz));
  assign din_b = ca - 12'(cb * 12'(cz));

  always @(posedge clk) begin
    cyc++;
    dout_a <= mem[ram_addr_a];
    dout_b <= mem[ram_addr_b];
    if (ram_we) begin
      mem[ram_addr_a] = din_a;
      mem[ram_addr_b] = din_b;
    end
  end

  // Scoreboard: every write-back pops the next expected butterfly
  always @(negedge clk) if (rst_n) begin
    if (bf_valid) begin
      ca = dout_a; cb = dout_b; cz = bf_zeta_idx;
      va = ram_addr_a; vb = ram_addr_b; vcyc = cyc;
    end
    if (ram_we) begin
      exp_t e;
      writes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: write a=%0d b=%0d with nothing expected", ram_addr_a, ram_addr_b);
      end else begin
        e = sb.pop_front();
        if ({ram_addr_a, ram_addr_b, bf_zeta_idx, ntt_layer} !== e) begin
          failures++;
          $display("FAIL bf_order: got a=%0d b=%0d z=%0d l=%0d exp a=%0d b=%0d z=%0d l=%0d",
                   ram_addr_a, ram_addr_b, bf_zeta_idx, ntt_layer, e.a, e.b, e.z, e.l);
        end
      end
      checks++;
      if (cyc - vcyc !== BF_LAT || ram_addr_a !== va || ram_addr_b !== vb || bf_valid !== 1'b0) begin
        failures++;
        $display("FAIL wb_timing: lat=%0d exp %0d a=%0d/%0d b=%0d/%0d valid=%b",
                 cyc - vcyc, BF_LAT, ram_addr_a, va, ram_addr_b, vb, bf_valid);
      end
    end
    if (done) dones++;
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 12'(i);
      gold[i] = 12'(i);
    end
  endtask

  // Reference loop order of the Kyber ntt/invntt; also applies the golden butterflies
  task automatic plan_run(input bit inv);
    int k, l;
    logic [11:0] a, b;
    k = inv ? 127 : 1;
    l = 0;
    for (int len = inv ? 2 : 128; inv ? len <= 128 : len >= 2; len = inv ? len << 1 : len >> 1) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          sb.push_back({8'(j), 8'(j + len), 7'(k), 3'(l)});
          a = gold[j];
          b = gold[j + len];
          gold[j] = a + 12'(b * k);
          gold[j + len] = a - 12'(b * k);
        end
        k = inv ? k - 1 : k + 1;
      end
      l++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_mem: %0d words differ from golden, required 0", name, bad);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_sb_left: %0d butterflies never written, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ram_we, bf_valid, ram_addr_a, ram_addr_b, bf_zeta_idx, ntt_layer} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy, done, ram_we, bf_valid, ram_addr_a, ram_addr_b, bf_zeta_idx, ntt_layer});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, ram_we, bf_valid, done} !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle: busy/we/valid/done=%b required 0000", {busy, ram_we, bf_valid, done});
    end
  endtask

  task automatic test_first_butterflies();
    int c_read;
    init_mem();
    plan_run(1'b0);
    writes = 0;
    dones = 0;
    pulse_start();
    c_read = cyc;
    checks++;
    if ({busy, ram_we, bf_valid, ram_addr_a, ram_addr_b, bf_zeta_idx} !== {3'b100, 8'd0, 8'd128, 7'd1}) begin
      failures++;
      $display("FAIL first_read: busy=%b we=%b v=%b a=%0d b=%0d z=%0d required 1 0 0 0 128 1",
               busy, ram_we, bf_valid, ram_addr_a, ram_addr_b, bf_zeta_idx);
    end
    @(negedge clk);
    checks++;
    if (bf_valid !== 1'b1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL first_valid: valid=%b we=%b required 1 0", bf_valid, ram_we);
    end
    @(negedge clk);
    checks++;
    if (bf_valid !== 1'b0 || ram_we !== 1'b0 || ram_addr_b !== 8'd128) begin
      failures++;
      $display("FAIL first_wait: valid=%b we=%b b=%0d required 0 0 128", bf_valid, ram_we, ram_addr_b);
    end
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr_a !== 8'd0 || ram_addr_b !== 8'd128) begin
      failures++;
      $display("FAIL first_write: we=%b a=%0d b=%0d required 1 0 128", ram_we, ram_addr_a, ram_addr_b);
    end
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_addr_a !== 8'd1 || ram_addr_b !== 8'd129) begin
      failures++;
      $display("FAIL second_read: we=%b a=%0d b=%0d required 0 1 129", ram_we, ram_addr_a, ram_addr_b);
    end
    wait_done("fwd");
    checks++;
    if (cyc - c_read !== 3584 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fwd_length: done %0d cycles after first read busy=%b, required 3584 0", cyc - c_read, busy);
    end
    @(negedge clk);
    checks++;
    if (writes !== 896 || dones !== 1 || done !== 1'b0) begin
      failures++;
      $display("FAIL fwd_counts: writes=%0d dones=%0d done=%b required 896 1 0", writes, dones, done);
    end
    check_mem("fwd");
  endtask

  task automatic test_back_to_back();
    init_mem();
    plan_run(1'b0);
    plan_run(1'b0);
    writes = 0;
    dones = 0;
    @(negedge clk) start = 1'b1;
    wait_done("b2b_first");
    checks++;
    if (writes !== 896 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: writes=%0d busy=%b required 896 0", writes, busy);
    end
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ram_addr_a !== 8'd0 || ram_addr_b !== 8'd128) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b a=%0d b=%0d required 1 0 128", busy, ram_addr_a, ram_addr_b);
    end
    wait_done("b2b_second");
    @(negedge clk);
    checks++;
    if (writes !== 1792 || dones !== 2) begin
      failures++;
      $display("FAIL b2b_counts: writes=%0d dones=%0d required 1792 2", writes, dones);
    end
    check_mem("b2b");
  endtask

  task automatic test_abort();
    int n = 0, w;
    init_mem();
    plan_run(1'b0);
    writes = 0;
    dones = 0;
    pulse_start();
    while (!(writes == 300 && bf_valid === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (writes !== 300 || bf_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_reach: writes=%0d valid=%b required 300 1", writes, bf_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ram_we, bf_valid, ram_addr_a, ram_addr_b, bf_zeta_idx} !== 26'd0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b we=%b v=%b a=%0d b=%0d z=%0d required all 0",
               busy, ram_we, bf_valid, ram_addr_a, ram_addr_b, bf_zeta_idx);
    end
    w = writes;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (writes !== w || dones !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet: writes=%0d dones=%0d busy=%b required %0d 0 0", writes, dones, busy, w);
    end
    sb.delete();
    init_mem();
    plan_run(1'b0);
    writes = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || ram_addr_a !== 8'd0 || ram_addr_b !== 8'd128 || bf_zeta_idx !== 7'd1) begin
      failures++;
      $display("FAIL abort_restart: busy=%b a=%0d b=%0d z=%0d required 1 0 128 1",
               busy, ram_addr_a, ram_addr_b, bf_zeta_idx);
    end
    wait_done("abort_rerun");
    @(negedge clk);
    checks++;
    if (writes !== 896 || dones !== 1) begin
      failures++;
      $display("FAIL abort_rerun_counts: writes=%0d dones=%0d required 896 1", writes, dones);
    end
    check_mem("abort_rerun");
  endtask

`ifdef KYBER_INTT_EN
  task automatic test_intt();
    init_mem();
    plan_run(1'b1);
    writes = 0;
    dones = 0;
    mode = 1'b1;
    pulse_start();
    mode = 1'b0;
    checks++;
    if (bf_inv !== 1'b1 || ram_addr_a !== 8'd0 || ram_addr_b !== 8'd1 || bf_zeta_idx !== 7'd127 || ntt_layer !== 3'd0) begin
      failures++;
      $display("FAIL intt_first: inv=%b a=%0d b=%0d z=%0d l=%0d required 1 0 1 127 0",
               bf_inv, ram_addr_a, ram_addr_b, bf_zeta_idx, ntt_layer);
    end
    wait_done("intt");
    @(negedge clk);
    checks++;
    if (writes !== 896 || dones !== 1) begin
      failures++;
      $display("FAIL intt_counts: writes=%0d dones=%0d required 896 1", writes, dones);
    end
    check_mem("intt");
  endtask
`endif

  initial begin
    test_reset();
    test_first_butterflies();
    test_back_to_back();
    test_abort();
`ifdef KYBER_INTT_EN
    test_intt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
